// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate sequencer: state encoding,
// default widths and the number of operand pairs per dot product.
package mac_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int ACC_WIDTH_DEF = 18;
  localparam int PAIR_COUNT    = 4;
  localparam int SEL_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// Shift-add unsigned multiplier datapath: one partial product per step,
// fixed WIDTH steps per operand pair regardless of operand values.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_product;
  logic [CNT_W-1:0]   r_cnt;

  // NOTE: these are plain registers, not a memory array, so clearing them on
  // reset is cheap and makes a mid-operation abort leave no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else if (i_load) begin
      r_mcand   <= {{WIDTH{1'b0}}, i_a};
      r_mplier  <= i_b;
      r_product <= '0;
      r_cnt     <= '0;
    end else if (i_step) begin
      // NOTE: non-blocking updates mean the add below sees the pre-shift
      // multiplicand, matching "add first, then shift" within one cycle.
      if (r_mplier[0]) r_product <= r_product + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign o_product = r_product;
  // High during the WIDTH-th step, so the caller can leave MUL on that edge.
  assign o_last    = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product controller: steps the shared operand-mux select through four
// pairs, multiplies each with seq_mult and accumulates into the result.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     xin,
  input  logic [WIDTH-1:0]     win,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] result
);

  state_t r_state;
  state_t w_next_state;

  logic [SEL_W-1:0]     r_sel;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_result;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0]   w_product;
  logic                 w_last;
  logic                 w_load;
  logic                 w_step;
  logic                 w_last_pair;

  assign w_last_pair = (r_sel == SEL_W'(PAIR_COUNT - 1));
  assign w_acc_next  = r_acc + ACC_WIDTH'(w_product);

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (xin),
    .i_b      (win),
    .o_product(w_product),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_next_state = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next_state = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: w_next_state = ST_MUL;
      ST_MUL:  w_next_state = w_last ? ST_ACC : ST_MUL;
      ST_ACC:  w_next_state = w_last_pair ? ST_DONE : ST_LOAD;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_LOAD: begin w_load = 1'b1; busy = 1'b1; end
      ST_MUL:  begin w_step = 1'b1; busy = 1'b1; end
      ST_ACC:  busy = 1'b1;
      ST_DONE: begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Result is captured on entry to DONE so it is already valid while done=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_sel    <= '0;
          r_acc    <= '0;
          r_result <= '0;
        end
        ST_ACC: begin
          r_acc <= w_acc_next;
          if (w_last_pair) r_result <= w_acc_next;
          else             r_sel    <= r_sel + SEL_W'(1);
        end
        ST_DONE: r_sel <= '0;
        default: ;
      endcase
    end
  end

  assign sel    = r_sel;
  assign result = r_result;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: combinational operand banks feed
// xin/win from sel, and expected dot products come from plain arithmetic.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  xin, win;
  logic [1:0]  sel;
  logic        busy, done;
  logic [17:0] result;

  logic [7:0]  xs [4];
  logic [7:0]  ws [4];
  logic        x_ovr_en;
  logic [7:0]  x_ovr_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign xin = x_ovr_en ? x_ovr_val : xs[sel];
  assign win = ws[sel];

  mac_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .xin   (xin),
    .win   (win),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  function automatic logic [17:0] dot_model();
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(xs[i]) * int'(ws[i]);
    return 18'(s);
  endfunction

  // Launches one dot product from IDLE and waits (bounded) for done.
  // lat counts edges from the accepting edge to the edge that raises done.
  task automatic run_dot(output logic [17:0] res, output int lat,
                         output bit sel_ok, output bit pulse_ok,
                         output bit timed_out);
    sel_ok = 1'b1; pulse_ok = 1'b0; timed_out = 1'b1; lat = 0; res = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (sel !== 2'd0 || busy !== 1'b1) sel_ok = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = j; res = result; timed_out = 1'b0;
        break;
      end
      if (sel !== 2'(j / 10)) sel_ok = 1'b0;
    end
    if (!timed_out) begin
      @(posedge clk); #1;
      pulse_ok = (done === 1'b0) && (busy === 1'b0) && (sel === 2'd0);
    end
  endtask

  task automatic check_run(input string name, input logic [17:0] exp_res);
    logic [17:0] res;
    int lat;
    bit sel_ok, pulse_ok, timed_out;
    run_dot(res, lat, sel_ok, pulse_ok, timed_out);
    n_cmp++;
    if (timed_out) begin
      n_err++; $display("FAIL %s timeout: done never seen", name);
    end
    n_cmp++;
    if (res !== exp_res) begin
      n_err++; $display("FAIL %s result: got %0d want %0d", name, res, exp_res);
    end
    n_cmp++;
    if (lat !== 40) begin
      n_err++; $display("FAIL %s latency: got %0d want 40", name, lat);
    end
    n_cmp++;
    if (!sel_ok) begin
      n_err++; $display("FAIL %s sel sequence: got bad step want 0,1,2,3 per 10 cycles", name);
    end
    n_cmp++;
    if (!pulse_ok) begin
      n_err++; $display("FAIL %s done pulse: got not single-cycle want 1 cycle then idle", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x_ovr_en = 1'b0; x_ovr_val = '0;
    xs = '{8'd7, 8'd7, 8'd7, 8'd7};
    ws = '{8'd9, 8'd9, 8'd9, 8'd9};
    #1;
    n_cmp++;
    if ({busy, done, sel, result} !== 22'd0) begin
      n_err++; $display("FAIL reset_init: got busy=%b done=%b sel=%0d result=%0d want all 0",
                        busy, done, sel, result);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // Start a run and abort it in the middle of pair 2's multiply.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    n_cmp++;
    if (sel !== 2'd2 || busy !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_abort: got sel=%0d busy=%b want sel=2 busy=1", sel, busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sel, result} !== 22'd0) begin
      n_err++; $display("FAIL reset_mid_mul: got busy=%b done=%b sel=%0d result=%0d want all 0",
                        busy, done, sel, result);
    end
    #1 rst = 1'b0;
    xs = '{8'd1, 8'd1, 8'd1, 8'd1};
    ws = '{8'd1, 8'd1, 8'd1, 8'd1};
    @(posedge clk); #1;
    check_run("reset_rerun", 18'd4);
  endtask

  task automatic test_basic();
    xs = '{8'd1, 8'd2, 8'd3, 8'd4};
    ws = '{8'd5, 8'd6, 8'd7, 8'd8};
    check_run("basic", 18'd70);
  endtask

  task automatic test_overflow();
    xs = '{8'd255, 8'd255, 8'd255, 8'd255};
    ws = '{8'd255, 8'd255, 8'd255, 8'd255};
    check_run("overflow", 18'h3F804);
  endtask

  task automatic test_sparse();
    xs = '{8'd0, 8'd255, 8'd0, 8'd1};
    ws = '{8'd200, 8'd0, 8'd9, 8'd1};
    check_run("sparse", 18'd1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = 8'($urandom_range(0, 255));
        ws[i] = 8'($urandom_range(0, 255));
      end
      check_run($sformatf("random%0d", n), dot_model());
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int last_done = -1;
    int sel_viol = 0;
    int dbl_done = 0;
    logic [1:0] prev_sel = 2'd0;
    logic prev_done = 1'b0;
    xs = '{8'd2, 8'd2, 8'd2, 8'd2};
    ws = '{8'd2, 8'd2, 8'd2, 8'd2};
    start = 1'b1;
    for (int c = 1; c <= 170; c++) begin
      @(posedge clk); #1;
      if (!prev_done && sel < prev_sel) sel_viol++;
      if (done === 1'b1) begin
        if (prev_done) dbl_done++;
        n_done++;
        n_cmp++;
        if (result !== 18'd16) begin
          n_err++; $display("FAIL b2b result #%0d: got %0d want 16", n_done, result);
        end
        if (last_done >= 0) begin
          n_cmp++;
          if (c - last_done !== 42) begin
            n_err++; $display("FAIL b2b spacing: got %0d want 42", c - last_done);
          end
        end
        last_done = c;
      end
      prev_sel = sel;
      prev_done = done;
    end
    start = 1'b0;
    n_cmp++;
    if (n_done !== 4) begin
      n_err++; $display("FAIL b2b pulse count: got %0d want 4", n_done);
    end
    n_cmp++;
    if (sel_viol !== 0 || dbl_done !== 0) begin
      n_err++; $display("FAIL b2b handshake: got sel_viol=%0d dbl_done=%0d want 0/0",
                        sel_viol, dbl_done);
    end
    // Let any run launched by the still-held start drain back to IDLE.
    for (int c = 0; c < 60 && busy === 1'b1; c++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL b2b drain: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_operand_change();
    bit seen = 1'b0;
    xs = '{8'd3, 8'd0, 8'd0, 8'd0};
    ws = '{8'd4, 8'd0, 8'd0, 8'd0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    // Pair 0 operands are now latched; disturb the X mux output.
    x_ovr_val = 8'd9;
    x_ovr_en  = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (result !== 18'd12) begin
          n_err++; $display("FAIL operand_change result: got %0d want 12", result);
        end
        break;
      end
    end
    x_ovr_en = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL operand_change timeout: done never seen");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sparse();
    test_random();
    test_back_to_back();
    test_operand_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
